// File: rtl/param_mode_counter_pkg.sv
// Shared definitions for the parametrised mode counter: count-mode encodings
// used by the counter, its wrapper and the bench.
package param_mode_counter_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SAT      = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_PINGPONG = 2'b11;

  typedef logic [1:0] count_mode_t;

endpackage

// File: rtl/param_mode_counter_tick_prescaler.sv
// Enable-gated prescaler: emits one tick every prescale+1 enabled cycles.
module tick_prescaler
  import param_mode_counter_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre;
  logic [PRESCALE_W-1:0] pre_next;

  // Lowering prescale below pre lets pre run up through all-ones and wrap,
  // so no tick is produced early.
  always_comb begin
    tick     = 1'b0;
    pre_next = pre;
    if (clr) begin
      pre_next = '0;
    end else if (en) begin
      if (pre == prescale) begin
        tick     = 1'b1;
        pre_next = '0;
      end else begin
        pre_next = pre + PRE_ONE;
      end
    end else begin
      pre_next = pre;
    end
  end

  // Prescaler state register; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pre <= '0;
    end else begin
      pre <= pre_next;
    end
  end

endmodule

// File: rtl/param_mode_counter.sv
// Parametrised up/down counter with load, prescaled enable, wrap/saturate/
// one-shot/ping-pong modes, compare match and terminal-count pulse.
module param_mode_counter
  import param_mode_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  match,
  output logic                  done,
  output logic                  dir_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic             pp_dir;
  logic             pp_dir_next;
  logic             eff_up;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             done_next;
  logic             dir_out_next;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
    return up ? (v + ONE) : (v - ONE);
  endfunction

  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next-count logic: load beats tick; a finished one-shot ignores ticks.
  always_comb begin
    eff_up       = (mode == MODE_PINGPONG) ? pp_dir : dir;
    term         = eff_up ? '1 : '0;
    count_next   = count;
    tc_next      = 1'b0;
    done_next    = done;
    pp_dir_next  = pp_dir;
    if (load) begin
      count_next  = load_val;
      done_next   = 1'b0;
      pp_dir_next = dir;
    end else if (tick && !done) begin
      if (count == term) begin
        tc_next = 1'b1;
        case (mode)
          MODE_WRAP:     count_next = step(count, eff_up);
          MODE_SAT:      count_next = count;
          MODE_ONESHOT:  done_next  = 1'b1;
          MODE_PINGPONG: begin
            pp_dir_next = ~pp_dir;
            count_next  = step(count, ~pp_dir);
          end
          default:       count_next = count;
        endcase
      end else begin
        count_next = step(count, eff_up);
      end
    end else begin
      count_next = count;
    end
    dir_out_next = (mode == MODE_PINGPONG) ? pp_dir_next : dir;
  end

  // Output and direction registers; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count   <= '0;
      tc      <= 1'b0;
      match   <= 1'b0;
      done    <= 1'b0;
      pp_dir  <= 1'b1;
      dir_out <= (mode == MODE_PINGPONG) ? 1'b1 : dir;
    end else begin
      count   <= count_next;
      tc      <= tc_next;
      match   <= (count_next == cmp_val);
      done    <= done_next;
      pp_dir  <= pp_dir_next;
      dir_out <= dir_out_next;
    end
  end

endmodule

// File: tb/tb_param_mode_counter.sv
// Self-checking bench for param_mode_counter: directed vector table, hand
// sequences for multi-cycle corners, then random stimulus against a model.
module tb_param_mode_counter;
  import param_mode_counter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] cmp_val;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       match;
  logic       done;
  logic       dir_out;

  int vectors;
  int miscompares;

  // Behavioural model state, plain integers.
  int m_count, m_pre, m_tc, m_match, m_done, m_ppup, m_dirout;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] lv;
    logic [7:0] cmp;
    logic [3:0] ps;
    logic [7:0] e_count;
    logic       e_tc;
    logic       e_match;
    logic       e_done;
    logic       e_dirout;
  } vec_t;

  vec_t tbl[$];

  param_mode_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .cmp_val  (cmp_val),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .match    (match),
    .done     (done),
    .dir_out  (dir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic d, logic [1:0] m, logic l,
                              logic [7:0] lv, logic [7:0] c, logic [3:0] p,
                              logic [7:0] ec, logic etc, logic em, logic ed, logic edo);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv; v.cmp = c; v.ps = p;
    v.e_count = ec; v.e_tc = etc; v.e_match = em; v.e_done = ed; v.e_dirout = edo;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock using the current inputs.
  task automatic model_step();
    int up, t, tick;
    if (rst_n) begin
      m_count = 0; m_tc = 0; m_match = 0; m_done = 0; m_pre = 0; m_ppup = 1;
      m_dirout = (mode == MODE_PINGPONG) ? 1 : int'(dir);
      return;
    end
    tick = 0;
    m_tc = 0;
    if (load) begin
      m_count = int'(load_val); m_pre = 0; m_done = 0; m_ppup = int'(dir);
    end else begin
      if (en) begin
        if (m_pre == int'(prescale)) begin tick = 1; m_pre = 0; end
        else m_pre = (m_pre + 1) % 16;
      end
      if (tick == 1 && m_done == 0) begin
        up = (mode == MODE_PINGPONG) ? m_ppup : int'(dir);
        t  = (up != 0) ? 255 : 0;
        if (m_count == t) begin
          m_tc = 1;
          if (mode == MODE_WRAP) m_count = (m_count + ((up != 0) ? 1 : 255)) % 256;
          else if (mode == MODE_ONESHOT) m_done = 1;
          else if (mode == MODE_PINGPONG) begin
            m_ppup  = 1 - m_ppup;
            m_count = (m_count + ((m_ppup != 0) ? 1 : 255)) % 256;
          end
        end else begin
          m_count = (m_count + ((up != 0) ? 1 : 255)) % 256;
        end
      end
    end
    m_match  = (m_count == int'(cmp_val)) ? 1 : 0;
    m_dirout = (mode == MODE_PINGPONG) ? m_ppup : int'(dir);
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic seq_chk(string nm, int ec, int etc, int ed);
    clk_step();
    chk({nm, ".count"}, 32'(count), 32'(ec));
    chk({nm, ".tc"}, 32'(tc), 32'(etc));
    chk({nm, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_count = 0; m_pre = 0; m_tc = 0; m_match = 0; m_done = 0; m_ppup = 1; m_dirout = 0;
    rst_n = 1'b1; en = 1'b0; dir = 1'b1; mode = MODE_WRAP; load = 1'b0;
    load_val = 8'h00; cmp_val = 8'h00; prescale = 4'h0;

    // reset with load asserted
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, MODE_WRAP, 1'b1, 8'h55, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, MODE_WRAP, 1'b1, 8'h55, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    // wrap up through FF
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_WRAP, 1'b1, 8'hFE, 8'h01, 4'h0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_WRAP, 1'b0, 8'h00, 8'h01, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_WRAP, 1'b0, 8'h00, 8'h01, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_WRAP, 1'b0, 8'h00, 8'h01, 4'h0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1));
    // saturate up
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_SAT, 1'b1, 8'hFD, 8'hFF, 4'h0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_SAT, 1'b0, 8'h00, 8'hFF, 4'h0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_SAT, 1'b0, 8'h00, 8'hFF, 4'h0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_SAT, 1'b0, 8'h00, 8'hFF, 4'h0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_SAT, 1'b0, 8'h00, 8'hFF, 4'h0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1));
    // ping-pong reversal at FF, then load wins over a coincident tick
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 1'b1, 8'hFE, 8'hFE, 4'h0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 1'b0, 8'h00, 8'hFE, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 1'b0, 8'h00, 8'hFE, 4'h0, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 1'b0, 8'h00, 8'hFE, 4'h0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, MODE_PINGPONG, 1'b1, 8'h10, 8'hFE, 4'h0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, MODE_PINGPONG, 1'b0, 8'h00, 8'h0F, 4'h0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst; en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
      load = tbl[i].load; load_val = tbl[i].lv; cmp_val = tbl[i].cmp; prescale = tbl[i].ps;
      clk_step();
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d.tc", i), 32'(tc), 32'(tbl[i].e_tc));
      chk($sformatf("tbl%0d.match", i), 32'(match), 32'(tbl[i].e_match));
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.dir_out", i), 32'(dir_out), 32'(tbl[i].e_dirout));
    end

    // wrap down, prescale 3, with an en=0 gap mid-period
    rst_n = 1'b0; mode = MODE_WRAP; dir = 1'b0; prescale = 4'd3; en = 1'b1; cmp_val = 8'h80;
    load = 1'b1; load_val = 8'h02;
    seq_chk("pre_load", 8'h02, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) seq_chk("pre_wait", 8'h02, 0, 0);
    seq_chk("pre_tick1", 8'h01, 0, 0);
    for (int i = 0; i < 2; i++) seq_chk("pre_run", 8'h01, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) seq_chk("pre_frozen", 8'h01, 0, 0);
    en = 1'b1;
    seq_chk("pre_resume", 8'h01, 0, 0);
    seq_chk("pre_tick2", 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) seq_chk("pre_wait2", 8'h00, 0, 0);
    seq_chk("pre_wrap", 8'hFF, 1, 0);
    seq_chk("pre_tc_drop", 8'hFF, 0, 0);

    // one-shot down, sticky done, reload restarts
    mode = MODE_ONESHOT; prescale = 4'd0; load = 1'b1; load_val = 8'h03;
    seq_chk("os_load", 8'h03, 0, 0);
    load = 1'b0;
    seq_chk("os_02", 8'h02, 0, 0);
    seq_chk("os_01", 8'h01, 0, 0);
    seq_chk("os_00", 8'h00, 0, 0);
    seq_chk("os_term", 8'h00, 1, 1);
    for (int i = 0; i < 10; i++) seq_chk("os_hold", 8'h00, 0, 1);
    load = 1'b1; load_val = 8'h05;
    seq_chk("os_reload", 8'h05, 0, 0);
    load = 1'b0;
    seq_chk("os_resume", 8'h04, 0, 0);

    // randomized stimulus against the model
    rst_n = 1'b1;
    clk_step();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) prescale = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0);
      case ($urandom_range(0, 3))
        0:       load_val = 8'hFF;
        1:       load_val = 8'h00;
        default: load_val = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 15) == 0) cmp_val = 8'($urandom_range(0, 255));
      clk_step();
      chk("rnd.count", 32'(count), 32'(m_count));
      chk("rnd.tc", 32'(tc), 32'(m_tc));
      chk("rnd.match", 32'(match), 32'(m_match));
      chk("rnd.done", 32'(done), 32'(m_done));
      chk("rnd.dir_out", 32'(dir_out), 32'(m_dirout));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
